// File: rtl/k_video_pkg.sv
// Shared constants for the video block: register map, status bit indices and
// default beam counter widths.
package k_video_pkg;

  localparam int HW_DEF = 9;
  localparam int VW_DEF = 9;

  localparam logic [2:0] REG_CMP_LO   = 3'd0;
  localparam logic [2:0] REG_CMP_HI   = 3'd1;
  localparam logic [2:0] REG_STATUS   = 3'd2;
  localparam logic [2:0] REG_LAT_V_LO = 3'd3;
  localparam logic [2:0] REG_LAT_V_HI = 3'd4;
  localparam logic [2:0] REG_LAT_H    = 3'd5;
  localparam logic [2:0] REG_FRAME    = 3'd6;
  localparam logic [2:0] REG_GUN      = 3'd7;

  localparam int ST_RASTER = 0;
  localparam int ST_VBL    = 1;
  localparam int ST_GUN    = 2;

endpackage

// File: rtl/k_edge_fall.sv
// Pixel-enable gated sampler for an active-low timing strobe. fall is high
// for the whole enable period after the sample that saw 1 -> 0.
module k_edge_fall (
  input  logic clk,
  input  logic rst_n,
  input  logic ce,
  input  logic din,
  output logic fall
);

  logic cur;
  logic prev;

  // Two-stage sample history; both idle high so leaving reset is never an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur  <= 1'b1;
      prev <= 1'b1;
    end else if (ce) begin
      prev <= cur;
      cur  <= din;
    end
  end

  assign fall = prev & ~cur;

endmodule

// File: rtl/k_raster_irq.sv
// Raster position tracker and interrupt source. Rebuilds the beam position
// from the timing generator strobes, raises raster-line and vblank-start
// interrupts and exposes a CPU register file with a latched beam position.
// Optional light gun capture is built when K_RASTER_LIGHTGUN_EN is defined.
//
// CPU bus: there is no handshake. Any PIN_CLK cycle with PIN_CS low is a
// transfer. PIN_RW high reads: PIN_DB_OUT follows PIN_AB combinationally.
// PIN_RW low writes PIN_DB_IN on that rising edge; repeated cycles rewrite.
module k_raster_irq
  import k_video_pkg::*;
#(
  parameter int HW = HW_DEF,
  parameter int VW = VW_DEF
) (
  input  logic          PIN_CLK,
  input  logic          PIN_RESET,
  input  logic          PIN_CE,
  input  logic          PIN_NHLD,
  input  logic          PIN_NVLD,
  input  logic          PIN_NHBK,
  input  logic          PIN_NVBK,
`ifdef K_RASTER_LIGHTGUN_EN
  input  logic          PIN_NTRIG,
`endif
  input  logic          PIN_CS,
  input  logic          PIN_RW,
  input  logic [2:0]    PIN_AB,
  input  logic [7:0]    PIN_DB_IN,
  output logic [7:0]    PIN_DB_OUT,
  output logic          PIN_IRQ,
  output logic [HW-1:0] PIN_HPOS,
  output logic [VW-1:0] PIN_VPOS,
  output logic          PIN_ACTIVE
);

  localparam logic [HW-1:0] H_MAX = {HW{1'b1}};
  localparam logic [VW-1:0] V_MAX = {VW{1'b1}};

  logic [HW-1:0] hpos;
  logic [VW-1:0] vpos;
  logic [VW-1:0] vpos_next;
  logic [VW-1:0] cmp;
  logic [7:0]    frame;
  logic [7:0]    lat_h;
  logic          lat_v_hi;
  logic          lat_vbl;
  logic          in_vblank;
  logic          active;
  logic          irq;
  logic [2:0]    en;
  logic [2:0]    en_wr;
  logic [2:0]    status;
  logic [2:0]    st_set;
  logic [2:0]    st_clr;
  logic          hld_fall;
  logic          vld_fall;
  logic          vbk_fall;
  logic          raster_ev;
  logic          gun_ev;
  logic          wr;
  logic          rd_lat;

  assign wr     = ~PIN_CS & ~PIN_RW;
  assign rd_lat = ~PIN_CS & PIN_RW & (PIN_AB == REG_LAT_V_LO);

  k_edge_fall u_hld (
    .clk   (PIN_CLK),
    .rst_n (PIN_RESET),
    .ce    (PIN_CE),
    .din   (PIN_NHLD),
    .fall  (hld_fall)
  );

  k_edge_fall u_vld (
    .clk   (PIN_CLK),
    .rst_n (PIN_RESET),
    .ce    (PIN_CE),
    .din   (PIN_NVLD),
    .fall  (vld_fall)
  );

  k_edge_fall u_vbk (
    .clk   (PIN_CLK),
    .rst_n (PIN_RESET),
    .ce    (PIN_CE),
    .din   (PIN_NVBK),
    .fall  (vbk_fall)
  );

`ifdef K_RASTER_LIGHTGUN_EN
  logic       trig_fall;
  logic [7:0] gun_h;
  logic [7:0] gun_v;

  k_edge_fall u_trig (
    .clk   (PIN_CLK),
    .rst_n (PIN_RESET),
    .ce    (PIN_CE),
    .din   (PIN_NTRIG),
    .fall  (trig_fall)
  );

  // A pending gun hit blocks new triggers until software clears it.
  assign gun_ev = PIN_CE & trig_fall & ~status[ST_GUN];
  assign en_wr  = PIN_DB_IN[3:1];

  // Snapshot the beam position at the trigger instant.
  always_ff @(posedge PIN_CLK or negedge PIN_RESET) begin
    if (!PIN_RESET) begin
      gun_h <= 8'h00;
      gun_v <= 8'h00;
    end else if (gun_ev) begin
      gun_h <= hpos[HW-1 -: 8];
      gun_v <= vpos[7:0];
    end
  end
`else
  assign gun_ev = 1'b0;
  assign en_wr  = {1'b0, PIN_DB_IN[2:1]};
`endif

  // Next line value: frame start wins over line start; line count saturates.
  always_comb begin
    vpos_next = vpos;
    if (vld_fall) begin
      vpos_next = '0;
    end else if (hld_fall && (vpos != V_MAX)) begin
      vpos_next = vpos + VW'(1);
    end
  end

  // Fire only when a line start actually moves the beam onto the compare
  // line, so sitting saturated at the last line does not refire.
  assign raster_ev = PIN_CE & hld_fall & (vpos_next != vpos) & (vpos_next == cmp);

  // Beam position, frame count and display-area flags advance on pixel enable.
  always_ff @(posedge PIN_CLK or negedge PIN_RESET) begin
    if (!PIN_RESET) begin
      hpos      <= '0;
      vpos      <= '0;
      frame     <= 8'h00;
      active    <= 1'b0;
      in_vblank <= 1'b0;
    end else if (PIN_CE) begin
      if (hld_fall) begin
        hpos <= '0;
      end else if (hpos != H_MAX) begin
        hpos <= hpos + HW'(1);
      end
      vpos <= vpos_next;
      if (vld_fall) begin
        frame <= frame + 8'd1;
      end
      active    <= PIN_NHBK & PIN_NVBK;
      in_vblank <= ~PIN_NVBK;
    end
  end

  // Status set/clear terms; a set in the same cycle as a clear wins.
  always_comb begin
    st_set            = 3'b000;
    st_set[ST_RASTER] = raster_ev;
    st_set[ST_VBL]    = PIN_CE & vbk_fall;
    st_set[ST_GUN]    = gun_ev;
    st_clr            = 3'b000;
    if (wr && (PIN_AB == REG_STATUS)) begin
      st_clr = PIN_DB_IN[2:0];
    end
  end

  // CPU-writable registers and the sticky status bits.
  always_ff @(posedge PIN_CLK or negedge PIN_RESET) begin
    if (!PIN_RESET) begin
      cmp    <= V_MAX;
      en     <= 3'b000;
      status <= 3'b000;
    end else begin
      if (wr && (PIN_AB == REG_CMP_LO)) begin
        cmp[7:0] <= PIN_DB_IN;
      end
      if (wr && (PIN_AB == REG_CMP_HI)) begin
        cmp[VW-1] <= PIN_DB_IN[0];
        en        <= en_wr;
      end
      status <= (status & ~st_clr) | st_set;
    end
  end

  // Interrupt line follows the status register one clock later.
  always_ff @(posedge PIN_CLK or negedge PIN_RESET) begin
    if (!PIN_RESET) begin
      irq <= 1'b1;
    end else begin
      irq <= ~|(status & en);
    end
  end

  // Reading the low line byte freezes the rest of the position for later reads.
  always_ff @(posedge PIN_CLK or negedge PIN_RESET) begin
    if (!PIN_RESET) begin
      lat_vbl  <= 1'b0;
      lat_v_hi <= 1'b0;
      lat_h    <= 8'h00;
    end else if (rd_lat) begin
      lat_vbl  <= in_vblank;
      lat_v_hi <= vpos[VW-1];
      lat_h    <= hpos[HW-1 -: 8];
    end
  end

  // Register read mux, combinational from the address.
  always_comb begin
    PIN_DB_OUT = 8'h00;
    case (PIN_AB)
      REG_CMP_LO:   PIN_DB_OUT = cmp[7:0];
      REG_CMP_HI:   PIN_DB_OUT = {4'b0000, en, cmp[VW-1]};
      REG_STATUS:   PIN_DB_OUT = {5'b00000, status};
      REG_LAT_V_LO: PIN_DB_OUT = vpos[7:0];
      REG_LAT_V_HI: PIN_DB_OUT = {6'b000000, lat_vbl, lat_v_hi};
`ifdef K_RASTER_LIGHTGUN_EN
      REG_LAT_H:    PIN_DB_OUT = status[ST_GUN] ? gun_h : lat_h;
      REG_GUN:      PIN_DB_OUT = gun_v;
`else
      REG_LAT_H:    PIN_DB_OUT = lat_h;
      REG_GUN:      PIN_DB_OUT = 8'h00;
`endif
      REG_FRAME:    PIN_DB_OUT = frame;
      default:      PIN_DB_OUT = 8'h00;
    endcase
  end

  assign PIN_HPOS   = hpos;
  assign PIN_VPOS   = vpos;
  assign PIN_IRQ    = irq;
  assign PIN_ACTIVE = active;

endmodule

// File: doc/k_raster_irq.md
Name: k_raster_irq

Overview:
- Raster position tracker and interrupt source. It sits directly downstream of the video timing generator and consumes that generator's NHLD/NVLD line/frame pulses and NHBK/NVBK blanking outputs.
- Rebuilds the pixel (H) and line (V) beam position, raises programmable raster-line and vblank-start interrupts, and exposes a CPU-readable latched beam position and frame counter.
- Feeds the CPU IRQ line and the sprite/tile fetch logic, which uses the PIN_HPOS/PIN_VPOS outputs.

Parameters:
- HW, 9, width of H position counter.
- VW, 9, width of V position counter and compare line.

Ports:
- PIN_CLK  in  1  master clock; all state on rising edge.
- PIN_RESET  in  1  asynchronous, active-low reset.
- PIN_CE  in  1  pixel clock enable; timing inputs sampled and counters advance only when high.
- PIN_NHLD  in  1  line start from timing generator, active low.
- PIN_NVLD  in  1  frame start from timing generator, active low.
- PIN_NHBK  in  1  horizontal blank, active low.
- PIN_NVBK  in  1  vertical blank, active low.
- PIN_CS  in  1  CPU chip select, active low.
- PIN_RW  in  1  1 = read, 0 = write.
- PIN_AB  in  3  register address.
- PIN_DB_IN  in  8  CPU write data.
- PIN_DB_OUT  out  8  CPU read data, combinational from address.
- PIN_IRQ  out  1  interrupt, active low.
- PIN_HPOS  out  HW  current pixel position.
- PIN_VPOS  out  VW  current line position.
- PIN_ACTIVE  out  1  high when both NHBK and NVBK are high (active display).

Behaviour:
- Reset values:
  - HPOS = 0, VPOS = 0, frame counter = 0.
  - Compare line = 0x1FF, IRQ enable = 0, status = 0.
  - Latched position = 0.
  - PIN_IRQ = 1, PIN_ACTIVE = 0.
  - Input edge registers = 1.
- Input sampling: on each CE cycle, register NHLD, NVLD and NVBK once; a falling edge is the previous sample = 1 and the current sample = 0.
- Edge latency: one CE cycle from input change to edge detect; counter effect on the following CE edge.
- H counter: on a line-start edge HPOS is cleared to 0, otherwise it increments per CE. It saturates at 2^HW-1 and does not wrap.
- V counter:
  - On a line-start edge, VPOS increments, saturating at 2^VW-1.
  - A frame-start edge clears VPOS to 0.
  - If line start and frame start coincide, the frame start wins (VPOS = 0).
- Frame counter: 8 bits, increments on each frame-start edge and wraps 255 -> 0.
- Raster event: on the CE cycle where a line-start edge makes the new VPOS equal the compare line, set status bit0.
- Vblank event: a falling edge of NVBK sets status bit1.
- IRQ: PIN_IRQ = ~|(status[1:0] & enable[1:0]), registered, one PIN_CLK after the status update.
- Register map (AB):
  - 0 W/R: compare line[7:0].
  - 1 W/R: bit0 = compare line[8]; bit1 = raster IRQ enable; bit2 = vblank IRQ enable.
  - 2 R: status {5'b0, b2, b1, b0}. W: write-1-to-clear per bit.
  - 3 R: latched VPOS[7:0]. Every PIN_CLK cycle with CS low, RW high and AB=3, the latch captures {in_vblank, VPOS, HPOS[8:1]}; DB_OUT shows the live value in that cycle.
  - 4 R: {6'b0, latched in_vblank, latched VPOS[8]}.
  - 5 R: latched HPOS[8:1].
  - 6 R: frame counter.
  - 7 R: 0 (lightgun option below).
- Writes: take effect on every PIN_CLK cycle with CS=0 and RW=0. Writing repeatedly is harmless.
- Status clear vs. event: if a clear and a set of the same bit fall in the same cycle, the set wins.
- Disabled sources: status still latches while a source is disabled. Enabling it with a pending bit asserts IRQ on the next cycle.
- Reset mid-frame: everything returns to reset values immediately. The first line-start edge counts from VPOS 0 -> 1 until a frame start is seen.

Optional Feature:
- Macro: K_RASTER_LIGHTGUN_EN.
- With it: add input PIN_NTRIG (active low).
  - A falling edge, sampled on CE, captures HPOS[8:1] and VPOS[7:0] into gun registers and sets status bit2.
  - Reads: AB=7 returns gun VPOS[7:0]; AB=5 returns gun HPOS while status bit2 = 1.
  - enable bit3 (AB=1 bit3) gates bit2 into IRQ.
  - Further triggers are ignored while bit2 = 1.
- Without it: no port, status bit2 = 0, AB=7 reads 0.

Decomposition:
- Shared package k_video_pkg holds:
  - register address constants (REG_CMP_LO..REG_FRAME);
  - status bit indices ST_RASTER, ST_VBL, ST_GUN;
  - HW/VW defaults.
- One sub-module, k_edge_fall: a CE-gated sampler with a falling-edge pulse output, reset to 1. It is instantiated for NHLD, NVLD, NVBK and NTRIG.

Test Plan:
- Reset, then 384 CE with NHLD pulsing low every 384 CE -> HPOS ramps 0..383 and restarts at 0; VPOS increments once per pulse.
- Write AB0=0x10, AB1=0x02, then run lines -> status bit0 set and PIN_IRQ=0 on the line where VPOS becomes 16; write AB2=0x01 -> PIN_IRQ=1.
- NVLD and NHLD falling in the same CE -> VPOS=0 and frame counter +1; after 256 frames the counter reads 0.
- Hold NHLD low-then-high pulses past line 511 -> VPOS saturates at 511; compare line 0x1FF fires exactly once.
- Same-cycle W1C of bit1 and NVBK fall -> bit1 remains 1 and IRQ stays asserted.
- Read AB3 at VPOS=0x123 -> DB_OUT=0x23; then AB4 -> 0x01 (bit8), unchanged even though VPOS advances between the reads.
